// File: rtl/tick_divider_if.sv
// tick_divider_if: control/status bundle of the tick divider (clock/reset stay plain ports).
interface tick_divider_if #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [BURST_W-1:0] burst_len;
  logic               div_load;
  logic [WIDTH-1:0]   div_value;
  logic               tick;
  logic               out;
  logic               busy;
  logic               done;
  logic [31:0]        tick_total;
  modport master (
    output start, stop, mode, burst_len, div_load, div_value,
    input  tick, out, busy, done, tick_total
  );
  modport slave (
    input  start, stop, mode, burst_len, div_load, div_value,
    output tick, out, busy, done, tick_total
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: programmable tick/square-wave generator, continuous or burst.
// Define TICK_DIVIDER_TOTAL_EN to build the saturating tick_total counter.
module tick_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int BURST_W     = 8
) (
  input logic          clock,
  input logic          reset,
  tick_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV < 2 ? 2 : DEFAULT_DIV);
  state_t             state, state_nx;
  logic [WIDTH-1:0]   cnt, div_reg, pend, div_clamp;
  logic [BURST_W-1:0] remain;
  logic               pend_v, burst, wrap, tick_set, go, tick_r, out_r;
  assign div_clamp = bus.div_value < WIDTH'(2) ? WIDTH'(2) : bus.div_value;
  assign go        = state == IDLE && bus.start && !bus.stop;
  assign wrap      = state == RUN && cnt == div_reg - WIDTH'(1);
  // stop beats a tick on the same edge; an empty burst never ticks
  assign tick_set  = wrap && !bus.stop && !(burst && remain == '0);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? RUN : IDLE;
      RUN:     state_nx = bus.stop ? IDLE :
                          burst && (remain == '0 || (tick_set && remain == BURST_W'(1))) ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      cnt     <= '0;
      div_reg <= DEF_DIV;
      pend    <= '0;
      pend_v  <= 1'b0;
      burst   <= 1'b0;
      remain  <= '0;
      tick_r  <= 1'b0;
      out_r   <= 1'b0;
    end else begin
      cnt    <= state == RUN && state_nx == RUN && !wrap ? cnt + WIDTH'(1) : '0;
      tick_r <= tick_set;
      out_r  <= state_nx == IDLE ? 1'b0 : tick_set ? ~out_r : out_r;
      if (go) begin
        burst  <= bus.mode;
        remain <= bus.burst_len;
      end else if (tick_set && burst) remain <= remain - BURST_W'(1);
      // a divisor change while running waits for the wrap so no period is cut short
      if (state != RUN || wrap) begin
        div_reg <= bus.div_load ? div_clamp : pend_v ? pend : div_reg;
        pend_v  <= 1'b0;
      end else if (bus.div_load) begin
        pend   <= div_clamp;
        pend_v <= 1'b1;
      end
    end
  assign bus.tick = tick_r;
  assign bus.out  = out_r;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
`ifdef TICK_DIVIDER_TOTAL_EN
  logic [31:0] total;
  always_ff @(posedge clock)
    if (reset) total <= '0;
    else if (tick_set && total != 32'hFFFF_FFFF) total <= total + 32'd1;
  assign bus.tick_total = total;
`else
  assign bus.tick_total = 32'd0;
`endif
endmodule
